led_pwm_driver: RTL and testbench

Brightness/blink stage directly downstream of the 8-bit LED PIO register in the lab SoC. It consumes the PIO's `out_port` value and drives the board LEDs with a global PWM duty, optional blink, and polarity invert. Software controls it through its own zero-wait-state Avalon-MM slave. It sits between the PIO and the LEDR pins.

---
 rtl/led_pwm_driver_pkg.sv | 30 +++
 rtl/led_pwm_driver_if.sv | 26 ++
 rtl/led_pwm_driver_timebase.sv | 79 +++++++
 rtl/led_pwm_driver.sv | 110 +++++++++++
 tb/tb_led_pwm_driver.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pwm_driver_pkg.sv
// Shared constants and types for the LED PWM driver: register map, CTRL layout,
// reset values and the PWM step count.
package led_drv_pkg;

  typedef enum logic [1:0] {
    ADDR_CTRL   = 2'd0,
    ADDR_DUTY   = 2'd1,
    ADDR_BLINK  = 2'd2,
    ADDR_STATUS = 2'd3
  } reg_addr_e;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_BLINK_EN_BIT = 1;
  localparam int CTRL_INVERT_BIT   = 2;

  // Field order mirrors CTRL[2:0] so the struct can be cast to and from the bus.
  typedef struct packed {
    logic invert;
    logic blink_en;
    logic enable;
  } ctrl_t;

  localparam logic [2:0]  CTRL_RST  = 3'h1;
  localparam logic [7:0]  DUTY_RST  = 8'hFF;
  localparam logic [15:0] BLINK_RST = 16'h01F4;

  localparam int         PWM_STEPS = 255;
  localparam logic [7:0] PC_LAST   = 8'(PWM_STEPS - 1);

endpackage

// File: rtl/led_pwm_driver_if.sv
// Zero-wait-state Avalon-MM slave bus used by software to program the LED driver.
interface led_pwm_driver_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/led_pwm_driver_timebase.sv
// Prescaler, 255-step PWM counter and blink phase generator for the LED driver.
module led_pwm_timebase
  import led_drv_pkg::*;
#(
  parameter int PWM_DIV = 195
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] half_period,
  input  logic        blink_clr,
  output logic [7:0]  pc,
  output logic        pend,
  output logic        phase
);

  localparam int            PRE_W    = $clog2(PWM_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       pc_q, pc_d;
  logic [15:0]      bc_q, bc_d;
  logic             phase_q, phase_d;
  logic             tick;
  logic             pend_int;

  always_comb begin
    tick     = enable && (pre_q == PRE_LAST);
    pend_int = tick && (pc_q == PC_LAST);

    pre_d = pre_q;
    pc_d  = pc_q;
    if (!enable) begin
      pre_d = '0;
      pc_d  = '0;
    end else if (tick) begin
      pre_d = '0;
      pc_d  = (pc_q == PC_LAST) ? 8'd0 : pc_q + 8'd1;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  // A BLINK write restarts the blink cycle lit, taking priority over a coincident period end.
  always_comb begin
    bc_d    = bc_q;
    phase_d = phase_q;
    if (blink_clr || !enable || (half_period == 16'd0)) begin
      bc_d    = '0;
      phase_d = 1'b1;
    end else if (pend_int) begin
      if (bc_q == 16'(half_period - 16'd1)) begin
        bc_d    = '0;
        phase_d = ~phase_q;
      end else begin
        bc_d = bc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      pc_q    <= '0;
      bc_q    <= '0;
      phase_q <= 1'b1;
    end else begin
      pre_q   <= pre_d;
      pc_q    <= pc_d;
      bc_q    <= bc_d;
      phase_q <= phase_d;
    end
  end

  assign pc    = pc_q;
  assign pend  = pend_int;
  assign phase = phase_q;

endmodule

// File: rtl/led_pwm_driver.sv
// LED brightness/blink stage between the LED PIO and the LEDR pins, with its own
// Avalon-MM control registers, global PWM duty, blink and polarity invert.
module led_pwm_driver
  import led_drv_pkg::*;
#(
  parameter int PWM_DIV = 195
) (
  input  logic              clk,
  input  logic              reset_n,
  led_pwm_driver_if.slave   bus,
  input  logic [7:0]        led_in,
  output logic [7:0]        led_out
);

  ctrl_t       ctrl_q, ctrl_d;
  logic [7:0]  duty_q, duty_d;
  logic [15:0] half_period_q, half_period_d;
  logic [7:0]  duty_active_q, duty_active_d;
  logic [7:0]  led_q, led_d;
  logic [7:0]  led_out_q, led_out_d;

  reg_addr_e   addr;
  logic        wr;
  logic        blink_clr;
  logic [7:0]  pc;
  logic        pend;
  logic        phase;
  logic        pwm_on;
  logic        on;
  logic        unused_wdata;

  assign addr         = reg_addr_e'(bus.address);
  assign wr           = bus.chipselect && !bus.write_n;
  assign blink_clr    = wr && (addr == ADDR_BLINK);
  assign unused_wdata = ^bus.writedata[31:16];

  led_pwm_timebase #(
    .PWM_DIV (PWM_DIV)
  ) u_timebase (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (ctrl_q.enable),
    .half_period (half_period_q),
    .blink_clr   (blink_clr),
    .pc          (pc),
    .pend        (pend),
    .phase       (phase)
  );

  always_comb begin
    ctrl_d        = ctrl_q;
    duty_d        = duty_q;
    half_period_d = half_period_q;
    if (wr) begin
      case (addr)
        ADDR_CTRL:   ctrl_d        = ctrl_t'(bus.writedata[2:0]);
        ADDR_DUTY:   duty_d        = bus.writedata[7:0];
        ADDR_BLINK:  half_period_d = bus.writedata[15:0];
        default:     ;
      endcase
    end
  end

  // Duty only changes at a period boundary so a PWM period is never cut short.
  always_comb begin
    duty_active_d = duty_active_q;
    if (!ctrl_q.enable || pend) begin
      duty_active_d = duty_q;
    end
  end

  always_comb begin
    led_d     = led_in;
    pwm_on    = (pc < duty_active_q);
    on        = ctrl_q.enable && pwm_on && (phase || !ctrl_q.blink_en);
    led_out_d = (on ? led_q : 8'h00) ^ {8{ctrl_q.invert}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q        <= ctrl_t'(CTRL_RST);
      duty_q        <= DUTY_RST;
      half_period_q <= BLINK_RST;
      duty_active_q <= DUTY_RST;
      led_q         <= 8'h00;
      led_out_q     <= 8'h00;
    end else begin
      ctrl_q        <= ctrl_d;
      duty_q        <= duty_d;
      half_period_q <= half_period_d;
      duty_active_q <= duty_active_d;
      led_q         <= led_d;
      led_out_q     <= led_out_d;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (addr)
      ADDR_CTRL:   bus.readdata[2:0]  = ctrl_q;
      ADDR_DUTY:   bus.readdata[7:0]  = duty_q;
      ADDR_BLINK:  bus.readdata[15:0] = half_period_q;
      ADDR_STATUS: bus.readdata[9:0]  = {(duty_active_q != duty_q), phase, led_out_q};
      default:     ;
    endcase
  end

  assign led_out = led_out_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Self-checking bench for led_pwm_driver; expectations come from a cycle-count
// based reference model of the register map, PWM period and blink schedule.
module tb_led_pwm_driver;
  import led_drv_pkg::*;

  localparam int DIV    = 4;
  localparam int PERIOD = DIV * PWM_STEPS;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] led_in = 8'h00;
  logic [7:0] led_out;

  led_pwm_driver_if bus ();

  led_pwm_driver #(
    .PWM_DIV (DIV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .led_in  (led_in),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: m_t counts enabled clocks since the timebase last started,
  // m_k counts period ends since the blink schedule last restarted.
  logic [2:0]  m_ctrl;
  logic [7:0]  m_duty;
  logic [15:0] m_half;
  logic [7:0]  m_dact;
  logic [7:0]  m_led_q;
  logic [7:0]  m_out;
  int          m_t;
  int          m_k;

  function automatic logic m_phase();
    if (m_half == 16'd0) return 1'b1;
    return ((m_k / int'(m_half)) % 2) == 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {29'd0, m_ctrl};
      2'd1:    return {24'd0, m_duty};
      2'd2:    return {16'd0, m_half};
      default: return {22'd0, (m_dact != m_duty), m_phase(), m_out};
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl  = 3'h1;
    m_duty  = 8'hFF;
    m_half  = 16'h01F4;
    m_dact  = 8'hFF;
    m_led_q = 8'h00;
    m_out   = 8'h00;
    m_t     = 0;
    m_k     = 0;
  endtask

  task automatic model_edge();
    logic       en, ben, inv, pend, on, wr;
    int         step_idx, new_t, new_k;
    logic [7:0] new_dact, new_out;
    en       = m_ctrl[0];
    ben      = m_ctrl[1];
    inv      = m_ctrl[2];
    step_idx = (m_t / DIV) % PWM_STEPS;
    pend     = en && ((m_t % PERIOD) == PERIOD - 1);
    on       = en && (step_idx < int'(m_dact)) && (m_phase() || !ben);
    new_out  = (on ? m_led_q : 8'h00) ^ {8{inv}};
    new_dact = (!en || pend) ? m_duty : m_dact;
    new_t    = en ? m_t + 1 : 0;
    new_k    = !en ? 0 : (pend ? m_k + 1 : m_k);
    wr       = bus.chipselect && !bus.write_n;
    if (wr) begin
      case (bus.address)
        2'd0: m_ctrl = bus.writedata[2:0];
        2'd1: m_duty = bus.writedata[7:0];
        2'd2: begin
          m_half = bus.writedata[15:0];
          new_k  = 0;
        end
        default: ;
      endcase
    end
    m_led_q = led_in;
    m_out   = new_out;
    m_dact  = new_dact;
    m_t     = new_t;
    m_k     = new_k;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = 32'd0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    step();
    bus_idle();
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = a;
    #1;
    d = bus.readdata;
    bus_idle();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] exp_regs [4];
    exp_regs[0] = 32'h1;
    exp_regs[1] = 32'hFF;
    exp_regs[2] = 32'h1F4;
    exp_regs[3] = 32'h1A5;
    bus_idle();
    reset_n = 1'b0;
    led_in  = 8'h5A;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (led_out !== 8'h00) $display("[TB] FAIL reset_hold: led_out=%h expected 00", led_out);
      else n_pass++;
    end
    reset_n = 1'b1;
    led_in  = 8'hA5;
    for (int i = 0; i < 3; i++) step();
    n_total++;
    if (led_out !== 8'hA5) $display("[TB] FAIL reset_first_out: led_out=%h expected a5", led_out);
    else n_pass++;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      n_total++;
      if (rd !== exp_regs[a]) $display("[TB] FAIL reset_reg%0d: read=%h expected %h", a, rd, exp_regs[a]);
      else n_pass++;
    end
  endtask

  task automatic test_duty_64();
    logic [31:0] rd;
    int          hi;
    led_in = 8'hFF;
    bus_write(2'd1, 32'd64);
    bus_read(2'd3, rd);
    n_total++;
    if (rd[9] !== 1'b1) $display("[TB] FAIL duty_pending_set: status[9]=%b expected 1", rd[9]);
    else n_pass++;
    for (int i = 0; i < PERIOD + 8 && m_dact != 8'd64; i++) begin
      step();
      bus_read(2'd3, rd);
      n_total++;
      if (led_out !== m_out || rd[9] !== (m_dact != m_duty))
        $display("[TB] FAIL duty_wait: led_out=%h pending=%b expected %h/%b", led_out, rd[9], m_out, (m_dact != m_duty));
      else n_pass++;
    end
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step();
      if (led_out === 8'hFF) hi++;
      n_total++;
      if (led_out !== m_out) $display("[TB] FAIL duty_64_cycle: led_out=%h expected %h", led_out, m_out);
      else n_pass++;
    end
    n_total++;
    if (hi != 64 * DIV) $display("[TB] FAIL duty_64_ontime: on cycles=%0d expected %0d (off %0d expected %0d)", hi, 64 * DIV, PERIOD - hi, PERIOD - 64 * DIV);
    else n_pass++;
    bus_read(2'd3, rd);
    n_total++;
    if (rd[9] !== 1'b0) $display("[TB] FAIL duty_pending_clear: status[9]=%b expected 0", rd[9]);
    else n_pass++;
  endtask

  task automatic test_duty_extremes();
    logic [7:0] d;
    logic [7:0] want;
    led_in = 8'hFF;
    for (int n = 0; n < 2; n++) begin
      d    = (n == 0) ? 8'h00 : 8'hFF;
      want = (n == 0) ? 8'h00 : 8'hFF;
      bus_write(2'd1, {24'd0, d});
      for (int i = 0; i < PERIOD + 8 && m_dact != d; i++) step();
      step();
      for (int i = 0; i < PERIOD + 8; i++) begin
        step();
        n_total++;
        if (led_out !== want) $display("[TB] FAIL duty_const_%0d: led_out=%h expected %h", d, led_out, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_blink();
    logic [31:0] rd;
    int          lit;
    bit          found;
    led_in = 8'hFF;
    bus_write(2'd2, 32'd2);
    bus_write(2'd0, 32'h3);
    lit = 0;
    for (int i = 0; i < 5 * PERIOD; i++) begin
      step();
      bus_read(2'd3, rd);
      if (i >= PERIOD && led_out === 8'hFF) lit++;
      n_total++;
      if (led_out !== m_out || rd[8] !== m_phase())
        $display("[TB] FAIL blink_cycle: led_out=%h phase=%b expected %h/%b", led_out, rd[8], m_out, m_phase());
      else n_pass++;
    end
    n_total++;
    if (lit != 2 * PERIOD) $display("[TB] FAIL blink_duty: lit cycles=%0d expected %0d", lit, 2 * PERIOD);
    else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 2 * PERIOD + 8 && !found; i++) begin
      step();
      if (led_out === 8'h00) found = 1'b1;
    end
    n_total++;
    if (!found) $display("[TB] FAIL blink_dark_timeout: led_out=%h expected 00 within budget", led_out);
    else n_pass++;
    bus_write(2'd2, 32'd2);
    step();
    bus_read(2'd3, rd);
    n_total++;
    if (led_out !== 8'hFF || rd[8] !== 1'b1) $display("[TB] FAIL blink_relit: led_out=%h phase=%b expected ff/1", led_out, rd[8]);
    else n_pass++;
  endtask

  task automatic test_disable_invert();
    logic [31:0] rd;
    bus_write(2'd1, 32'd64);
    bus_write(2'd0, 32'h4);
    step();
    n_total++;
    if (led_out !== 8'hFF) $display("[TB] FAIL disable_invert: led_out=%h expected ff", led_out);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      led_in = 8'($urandom);
      step();
      bus_read(2'd3, rd);
      n_total++;
      if (led_out !== 8'hFF || rd[8] !== 1'b1) $display("[TB] FAIL disable_hold: led_out=%h phase=%b expected ff/1", led_out, rd[8]);
      else n_pass++;
    end
    led_in = 8'h0F;
    step();
    bus_write(2'd0, 32'h5);
    step();
    n_total++;
    if (led_out !== 8'hF0) $display("[TB] FAIL reenable_invert: led_out=%h expected f0", led_out);
    else n_pass++;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      led_in = 8'($urandom);
      step();
      n_total++;
      if (led_out !== m_out) $display("[TB] FAIL reenable_cycle: led_out=%h expected %h", led_out, m_out);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    int          r;
    logic [1:0]  a;
    for (int i = 0; i < 4000; i++) begin
      led_in = 8'($urandom);
      r = $urandom_range(0, 99);
      if (r < 2) bus_write(2'd1, $urandom);
      else if (r == 2) bus_write(2'd0, {29'd0, 1'b1, 2'($urandom)} | 32'($urandom_range(0, 7) == 0 ? 0 : 1));
      else if (r == 3) bus_write(2'd2, 32'($urandom_range(0, 3)));
      else if (r == 4) bus_write(2'd3, $urandom);
      else step();
      n_total++;
      if (led_out !== m_out) $display("[TB] FAIL random_out: led_out=%h expected %h", led_out, m_out);
      else n_pass++;
      if (r >= 5 && r < 10) begin
        a = 2'($urandom);
        bus_read(a, rd);
        n_total++;
        if (rd !== m_read(a)) $display("[TB] FAIL random_read%0d: read=%h expected %h", a, rd, m_read(a));
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic [31:0] exp_regs [4];
    exp_regs[0] = 32'h1;
    exp_regs[1] = 32'hFF;
    exp_regs[2] = 32'h1F4;
    exp_regs[3] = 32'h100;
    led_in = 8'hFF;
    bus_write(2'd0, 32'h1);
    bus_write(2'd1, 32'hFF);
    for (int i = 0; i < PERIOD + 5; i++) step();
    bus_write(2'd1, 32'd10);
    bus_write(2'd2, 32'd7);
    for (int i = 0; i < 3; i++) step();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    n_total++;
    if (led_out !== 8'h00) $display("[TB] FAIL mid_reset_async: led_out=%h expected 00", led_out);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      n_total++;
      if (rd !== exp_regs[a]) $display("[TB] FAIL mid_reset_reg%0d: read=%h expected %h", a, rd, exp_regs[a]);
      else n_pass++;
    end
    for (int i = 0; i < 3 * DIV; i++) begin
      step();
      n_total++;
      if (led_out !== m_out) $display("[TB] FAIL mid_reset_restart: led_out=%h expected %h", led_out, m_out);
      else n_pass++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time budget expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus_idle();
    test_reset();
    test_duty_64();
    test_duty_extremes();
    test_blink();
    test_disable_invert();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
